// File: rtl/point_cal_pkg.sv
// Shared constants and the result-entry payload for the point_cal scheduler.
package point_cal_pkg;

  localparam int unsigned CAL_LAT_DEF = 5;
  localparam int unsigned WIDTH_DEF   = 10;
  localparam int unsigned ID_W_DEF    = 1;

  // One buffered datapath result tagged with the requester that issued it.
  typedef struct packed {
    logic [ID_W_DEF-1:0]     id;
    logic [4*WIDTH_DEF-1:0]  xi;
    logic [4*WIDTH_DEF-1:0]  yi;
    logic [4*WIDTH_DEF-1:0]  xo;
    logic [4*WIDTH_DEF-1:0]  yo;
  } entry_t;

endpackage

// File: rtl/pcs_result_fifo.sv
// Synchronous result FIFO for point_cal_sched.
// Ports: clk/rst_n (async active-low), push/push_data write side,
// pop read side (ignored when empty), head = oldest entry,
// full/empty/count status. A push into a full FIFO is accepted only
// when a pop frees the slot in the same cycle; otherwise it is dropped.
module pcs_result_fifo
  import point_cal_pkg::*;
#(
  parameter type         data_t = entry_t,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  data_t            push_data,
  input  logic             pop,
  output data_t            head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  data_t             mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;
  logic [CNT_W-1:0]  count_nxt;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Accept/remove decisions and the next occupancy.
  always_comb begin
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage, pointers (wrapping modulo DEPTH) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      count <= count_nxt;
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/point_cal_sched.sv
// Shares one fixed-latency point_cal datapath among NREQ requesters.
// Ports: clk, rst_n (async active-low);
//   req_valid/req_ready + packed req_xc/yc/xb/yb : round-robin request side
//   cal_xc/yc/xb/yb : registered datapath operands
//   cal_xi/yi/xo/yo : datapath results, valid CAL_LAT edges after an operand load
//   out_valid/out_ready/out_id/out_xi..yo : buffered result stream
//   busy : work in flight or buffered; err_ovf : sticky result-drop flag
// Issue is credit-gated against FIFO_DEPTH so the non-stallable datapath
// can never deliver a result the FIFO cannot hold.
module point_cal_sched
  import point_cal_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned NREQ       = 2,
  parameter int unsigned CAL_LAT    = CAL_LAT_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned ID_W      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_xc,
  input  logic [NREQ*WIDTH-1:0] req_yc,
  input  logic [NREQ*WIDTH-1:0] req_xb,
  input  logic [NREQ*WIDTH-1:0] req_yb,
  output logic [WIDTH-1:0]      cal_xc,
  output logic [WIDTH-1:0]      cal_yc,
  output logic [WIDTH-1:0]      cal_xb,
  output logic [WIDTH-1:0]      cal_yb,
  input  logic [4*WIDTH-1:0]    cal_xi,
  input  logic [4*WIDTH-1:0]    cal_yi,
  input  logic [4*WIDTH-1:0]    cal_xo,
  input  logic [4*WIDTH-1:0]    cal_yo,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ID_W-1:0]       out_id,
  output logic [4*WIDTH-1:0]    out_xi,
  output logic [4*WIDTH-1:0]    out_yi,
  output logic [4*WIDTH-1:0]    out_xo,
  output logic [4*WIDTH-1:0]    out_yo,
  output logic                  busy,
  output logic                  err_ovf
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [4*WIDTH-1:0] xi;
    logic [4*WIDTH-1:0] yi;
    logic [4*WIDTH-1:0] xo;
    logic [4*WIDTH-1:0] yo;
  } res_t;

  logic [ID_W-1:0]              rr_ptr;
  logic [CNT_W-1:0]             inflight;
  logic [CNT_W-1:0]             fifo_count;
  logic                         fifo_full;
  logic                         fifo_empty;
  res_t                         fifo_head;
  res_t                         push_data;
  logic                         issue_ok;
  logic                         found;
  logic [ID_W-1:0]              grant_id;
  int unsigned                  scan_idx;
  logic                         xfer;
  logic                         capture;
  logic                         pop;
  logic [WIDTH-1:0]             sel_xc;
  logic [WIDTH-1:0]             sel_yc;
  logic [WIDTH-1:0]             sel_xb;
  logic [WIDTH-1:0]             sel_yb;
  // Stage 0 is aligned with the cal_* load; stage CAL_LAT marks the cycle
  // in which cal_xi..yo hold that operation's result.
  logic [CAL_LAT:0]             tag_v;
  logic [CAL_LAT:0][ID_W-1:0]   tag_id;

  // Credit from registered counts only; a same-cycle pop frees nothing yet.
  assign issue_ok = (SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH);

  // Round-robin search from rr_ptr, operand select and grant.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    scan_idx = 0;
    sel_xc   = '0;
    sel_yc   = '0;
    sel_xb   = '0;
    sel_yb   = '0;
    req_ready = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = 32'(rr_ptr) + k;
      if (scan_idx >= NREQ) begin
        scan_idx = scan_idx - NREQ;
      end
      if (!found && req_valid[ID_W'(scan_idx)]) begin
        found    = 1'b1;
        grant_id = ID_W'(scan_idx);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_xc = req_xc[i*WIDTH +: WIDTH];
        sel_yc = req_yc[i*WIDTH +: WIDTH];
        sel_xb = req_xb[i*WIDTH +: WIDTH];
        sel_yb = req_yb[i*WIDTH +: WIDTH];
      end
    end
    // No grant while reset is asserted: nothing could be registered anyway.
    if (rst_n && issue_ok && found) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign xfer    = |(req_valid & req_ready);
  assign capture = tag_v[CAL_LAT];
  assign pop     = out_valid && out_ready;

  always_comb begin
    push_data    = '0;
    push_data.id = tag_id[CAL_LAT];
    push_data.xi = cal_xi;
    push_data.yi = cal_yi;
    push_data.xo = cal_xo;
    push_data.yo = cal_yo;
  end

  // Operand registers, RR pointer and tag pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_xc <= '0;
      cal_yc <= '0;
      cal_xb <= '0;
      cal_yb <= '0;
      rr_ptr <= '0;
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= {tag_v[CAL_LAT-1:0], xfer};
      tag_id <= {tag_id[CAL_LAT-1:0], grant_id};
      if (xfer) begin
        cal_xc <= sel_xc;
        cal_yc <= sel_yc;
        cal_xb <= sel_xb;
        cal_yb <= sel_yb;
        rr_ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
    end
  end

  // Operations issued but not yet captured, plus the sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      err_ovf  <= 1'b0;
    end else begin
      case ({xfer, capture})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
      if (capture && fifo_full && !pop) begin
        err_ovf <= 1'b1;
      end
    end
  end

  pcs_result_fifo #(
    .data_t (res_t),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_id    = fifo_head.id;
  assign out_xi    = fifo_head.xi;
  assign out_yi    = fifo_head.yi;
  assign out_xo    = fifo_head.xo;
  assign out_yo    = fifo_head.yo;
  assign busy      = (inflight != '0) || !fifo_empty;

endmodule

// File: tb/tb_point_cal_sched.sv
// Self-checking bench for point_cal_sched with a 5-stage datapath model.
module tb_point_cal_sched;

  localparam int unsigned WIDTH      = 10;
  localparam int unsigned NREQ       = 2;
  localparam int unsigned CAL_LAT    = 5;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned DW         = 4 * WIDTH;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_xc, req_yc, req_xb, req_yb;
  logic [WIDTH-1:0]      cal_xc, cal_yc, cal_xb, cal_yb;
  logic [DW-1:0]         cal_xi, cal_yi, cal_xo, cal_yo;
  logic                  out_valid;
  logic                  out_ready;
  logic [0:0]            out_id;
  logic [DW-1:0]         out_xi, out_yi, out_xo, out_yo;
  logic                  busy;
  logic                  err_ovf;

  logic [WIDTH-1:0] op_xc [NREQ];
  logic [WIDTH-1:0] op_yc [NREQ];
  logic [WIDTH-1:0] op_xb [NREQ];
  logic [WIDTH-1:0] op_yb [NREQ];

  point_cal_sched #(
    .WIDTH(WIDTH), .NREQ(NREQ), .CAL_LAT(CAL_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_xc(req_xc), .req_yc(req_yc), .req_xb(req_xb), .req_yb(req_yb),
    .cal_xc(cal_xc), .cal_yc(cal_yc), .cal_xb(cal_xb), .cal_yb(cal_yb),
    .cal_xi(cal_xi), .cal_yi(cal_yi), .cal_xo(cal_xo), .cal_yo(cal_yo),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_xi(out_xi), .out_yi(out_yi), .out_xo(out_xo), .out_yo(out_yo),
    .busy(busy), .err_ovf(err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_xc[i*WIDTH +: WIDTH] = op_xc[i];
      req_yc[i*WIDTH +: WIDTH] = op_yc[i];
      req_xb[i*WIDTH +: WIDTH] = op_xb[i];
      req_yb[i*WIDTH +: WIDTH] = op_yb[i];
    end
  end

  // The datapath's function of its four operands.
  function automatic logic [4*DW-1:0] dp_func(input logic [WIDTH-1:0] xc, yc, xb, yb);
    logic [DW-1:0] xi, yi, xo, yo;
    xi = {xc, yc, xb, yb};
    yi = DW'(xc) * DW'(yb) + DW'(yc);
    xo = {yb, xb, yc, xc} ^ 40'h5A_5A5A_5A5A;
    yo = DW'(xc) + DW'(yc) + DW'(xb) + DW'(yb) + 40'h12345;
    return {xi, yi, xo, yo};
  endfunction

  // Datapath model: result of the operands present after edge N appears after edge N+5.
  logic [4*DW-1:0] dp_pipe [CAL_LAT];
  initial for (int k = 0; k < CAL_LAT; k++) dp_pipe[k] = '0;
  always @(posedge clk) begin
    dp_pipe[0] <= dp_func(cal_xc, cal_yc, cal_xb, cal_yb);
    for (int k = 1; k < CAL_LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
  end
  assign {cal_xi, cal_yi, cal_xo, cal_yo} = dp_pipe[CAL_LAT-1];

  // Reference model state: issued-but-unpopped results in issue order.
  typedef struct {
    int              id;
    logic [4*DW-1:0] res;
    int              ready_at;
  } exp_t;

  exp_t          exp_q[$];
  int            ptr_m;
  int            outstanding;
  int            cyc;
  logic [DW-1:0] cal_m;
  int            mode;
  int            acc_dut;
  int            n_checks;
  int            n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_model();
    exp_q.delete();
    ptr_m       = 0;
    outstanding = 0;
    cal_m       = '0;
  endtask

  task automatic set_ops(input int i);
    op_xc[i] = WIDTH'($urandom());
    op_yc[i] = WIDTH'($urandom());
    op_xb[i] = WIDTH'($urandom());
    op_yb[i] = WIDTH'($urandom());
  endtask

  // Called at a falling edge; reset asserted there and released two falling edges later.
  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    check("rst_req_ready", 64'(req_ready), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_err_ovf", 64'(err_ovf), 0);
    check("rst_cal", 64'({cal_xc, cal_yc, cal_xb, cal_yb}), 0);
    check("rst_out_id", 64'(out_id), 0);
    check("rst_out_data", 64'(|{out_xi, out_yi, out_xo, out_yo}), 0);
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: check outputs against the model, advance the model, update requesters.
  task automatic cycle();
    logic [NREQ-1:0] rr_exp;
    int   gid;
    bit   ov_exp, xfer_m, pop_m;
    exp_t e;
    #1;
    rr_exp = '0;
    gid    = -1;
    if (outstanding < FIFO_DEPTH) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (ptr_m + k) % NREQ;
        if (gid < 0 && req_valid[idx]) gid = idx;
      end
    end
    if (gid >= 0) rr_exp[gid] = 1'b1;
    ov_exp = (exp_q.size() > 0) && (exp_q[0].ready_at <= cyc);
    check("req_ready", 64'(req_ready), 64'(rr_exp));
    check("out_valid", 64'(out_valid), 64'(ov_exp));
    check("busy", 64'(busy), 64'(outstanding != 0));
    check("err_ovf", 64'(err_ovf), 0);
    check("cal_ops", 64'({cal_xc, cal_yc, cal_xb, cal_yb}), 64'(cal_m));
    if (ov_exp) begin
      check("out_id", 64'(out_id), 64'(exp_q[0].id));
      check("out_xi", 64'(out_xi), 64'(exp_q[0].res[3*DW +: DW]));
      check("out_yi", 64'(out_yi), 64'(exp_q[0].res[2*DW +: DW]));
      check("out_xo", 64'(out_xo), 64'(exp_q[0].res[1*DW +: DW]));
      check("out_yo", 64'(out_yo), 64'(exp_q[0].res[0 +: DW]));
    end
    if ((req_valid & req_ready) != '0) acc_dut++;
    xfer_m = (gid >= 0);
    pop_m  = ov_exp && out_ready;
    @(posedge clk);
    cyc++;
    if (pop_m) begin
      void'(exp_q.pop_front());
      outstanding--;
    end
    if (xfer_m) begin
      e.id       = gid;
      e.res      = dp_func(op_xc[gid], op_yc[gid], op_xb[gid], op_yb[gid]);
      e.ready_at = cyc + CAL_LAT + 1;
      exp_q.push_back(e);
      outstanding++;
      cal_m = {op_xc[gid], op_yc[gid], op_xb[gid], op_yb[gid]};
      ptr_m = (gid + 1) % NREQ;
    end
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      bit raise;
      if (xfer_m && gid == i) req_valid[i] = 1'b0;
      case (mode)
        1:       raise = 1'b1;
        2:       raise = (i == 0);
        3:       raise = ($urandom_range(0, 1) == 1);
        default: raise = 1'b0;
      endcase
      if (!req_valid[i] && raise) begin
        set_ops(i);
        req_valid[i] = 1'b1;
      end
    end
    if (mode == 3) out_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    cyc       = 0;
    acc_dut   = 0;
    mode      = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_xc[i] = '0; op_yc[i] = '0; op_xb[i] = '0; op_yb[i] = '0;
    end
    clear_model();
    @(negedge clk);
    apply_reset();
    run(4);

    // Single request, held in the FIFO until out_ready rises.
    op_xc[0] = 10'h100; op_yc[0] = 10'h080; op_xb[0] = 10'h140; op_yb[0] = 10'h0C0;
    req_valid[0] = 1'b1;
    run(1);
    #1;
    check("t1_cal_xc", 64'(cal_xc), 64'h100);
    run(12);
    out_ready = 1'b1;
    run(4);

    // Both requesters always valid, consumer always ready.
    mode = 1;
    run(30);
    mode = 0;
    run(20);

    // Backpressure: credits run out after FIFO_DEPTH accepts.
    out_ready = 1'b0;
    mode      = 2;
    acc_dut   = 0;
    run(15);
    #1;
    check("bp_accepts", 64'(acc_dut), 4);
    check("bp_req_ready", 64'(req_ready), 0);
    out_ready = 1'b1;
    run(1);
    out_ready = 1'b0;
    run(4);
    check("bp_accepts_after_pop", 64'(acc_dut), 5);
    mode      = 0;
    out_ready = 1'b1;
    run(20);

    // Randomized traffic and consumer stalls.
    mode = 3;
    run(400);
    mode      = 0;
    out_ready = 1'b1;
    run(30);

    // Reset three cycles after an accept discards the operation.
    set_ops(1);
    req_valid[1] = 1'b1;
    run(1);
    run(3);
    apply_reset();
    run(10);

    // Idle: operands and pointer hold; pointer sits at 1 after a grant to 0.
    set_ops(0);
    req_valid[0] = 1'b1;
    run(1);
    run(20);
    set_ops(0);
    set_ops(1);
    req_valid = '1;
    run(1);
    #1;
    check("idle_ptr_grant_id", 64'(req_ready), 64'(2'b01));
    run(30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
